// File: rtl/fixpoint_pkg.sv
// Shared types and the transition function for the sequential fixpoint checker.
// Result and FSM encodings plus a width-generic next-state helper.
package fixpoint_pkg;

  // Widest state the generic next-state helper can handle.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_FIX   = 2'd1,
    RES_CYCLE = 2'd2
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // One counter transition on zero-extended operands of the given width:
  // hold at or above the limit when saturation is enabled, otherwise add
  // modulo 2^width with the carry discarded.
  function automatic logic [MAX_W-1:0] next_state(
    input logic [MAX_W-1:0] cur,
    input logic [MAX_W-1:0] inc,
    input logic [MAX_W-1:0] limit,
    input logic             limit_en,
    input int               width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] sum;
    if (width >= MAX_W) begin
      mask = ~32'd0;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    sum = (cur + inc) & mask;
    if (limit_en && (cur >= limit)) begin
      next_state = cur;
    end else begin
      next_state = sum;
    end
  endfunction

endpackage

// File: rtl/fixpoint_hist_cam.sv
// History register file for the fixpoint checker: one write port and a
// parallel compare against entries 0..cmp_last, returning the lowest match.
module fixpoint_hist_cam
  import fixpoint_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 5,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] cmp_data,
  input  logic [SW-1:0]    cmp_last,
  output logic             match_any,
  output logic [SW-1:0]    match_idx
);

  logic [WIDTH-1:0] mem_r [0:DEPTH];

  // Store one visited state per write; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_idx) <= DEPTH)) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Compare all valid entries at once; scan high to low so the lowest index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = {SW{1'b0}};
    for (int j = DEPTH; j >= 0; j--) begin
      if ((j <= int'(cmp_last)) && (mem_r[j] == cmp_data)) begin
        match_any = 1'b1;
        match_idx = SW'(j);
      end else begin
        match_any = match_any;
      end
    end
  end

endmodule

// File: rtl/fixpoint_seq_checker.sv
// Sequential fixpoint / lasso checker for a saturating or wrapping counter.
// Explores up to DEPTH transitions, one per clock, and reports FIX, CYCLE or NONE.
// Optional feature macro: HISTORY_CHECK_EN enables the history buffer and
// CYCLE detection; without it a revisit simply runs on to DEPTH.
module fixpoint_seq_checker
  import fixpoint_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 5,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] init_state,
  input  logic [WIDTH-1:0] inc,
  input  logic [WIDTH-1:0] limit,
  input  logic             limit_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [SW-1:0]    hit_step,
  output logic [SW-1:0]    cycle_to,
  output logic             o_1
);

  fsm_state_e       state_r,    state_nxt_s;
  logic [WIDTH-1:0] cur_r,      cur_nxt_s;
  logic [WIDTH-1:0] inc_r,      inc_nxt_s;
  logic [WIDTH-1:0] limit_r,    limit_nxt_s;
  logic             limit_en_r, limit_en_nxt_s;
  logic [SW-1:0]    step_r,     step_nxt_s;
  logic             busy_r,     busy_nxt_s;
  logic             done_r,     done_nxt_s;
  result_e          result_r,   result_nxt_s;
  logic [SW-1:0]    hit_step_r, hit_step_nxt_s;
  logic [SW-1:0]    cycle_to_r, cycle_to_nxt_s;
  logic             o_1_r,      o_1_nxt_s;

  logic [MAX_W-1:0] nxt_full_s;
  logic [WIDTH-1:0] nxt_s;
  logic [SW-1:0]    k_s;
  logic             hist_wr_en_s;
  logic [SW-1:0]    hist_wr_idx_s;
  logic [WIDTH-1:0] hist_wr_data_s;
  logic             match_any_s;
  logic [SW-1:0]    match_idx_s;

  assign nxt_full_s = next_state(MAX_W'(cur_r), MAX_W'(inc_r), MAX_W'(limit_r),
                                 limit_en_r, WIDTH);
  assign nxt_s      = nxt_full_s[WIDTH-1:0];
  assign k_s        = step_r + {{(SW-1){1'b0}}, 1'b1};

  generate
    if (WIDTH < MAX_W) begin : g_hi_sink
      logic unused_hi_s;
      assign unused_hi_s = ^nxt_full_s[MAX_W-1:WIDTH];
    end
  endgenerate

`ifdef HISTORY_CHECK_EN
  fixpoint_hist_cam #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_hist (
    .clk       (clk),
    .wr_en     (hist_wr_en_s),
    .wr_idx    (hist_wr_idx_s),
    .wr_data   (hist_wr_data_s),
    .cmp_data  (nxt_s),
    .cmp_last  (step_r),
    .match_any (match_any_s),
    .match_idx (match_idx_s)
  );
`else
  logic unused_hist_s;
  assign unused_hist_s = ^{hist_wr_en_s, hist_wr_idx_s, hist_wr_data_s};
  assign match_any_s   = 1'b0;
  assign match_idx_s   = {SW{1'b0}};
`endif

  // Next-state, datapath and output decisions for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    cur_nxt_s      = cur_r;
    inc_nxt_s      = inc_r;
    limit_nxt_s    = limit_r;
    limit_en_nxt_s = limit_en_r;
    step_nxt_s     = step_r;
    done_nxt_s     = 1'b0;
    result_nxt_s   = result_r;
    hit_step_nxt_s = hit_step_r;
    cycle_to_nxt_s = cycle_to_r;
    o_1_nxt_s      = o_1_r;
    hist_wr_en_s   = 1'b0;
    hist_wr_idx_s  = {SW{1'b0}};
    hist_wr_data_s = {WIDTH{1'b0}};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s    = ST_RUN;
          cur_nxt_s      = init_state;
          inc_nxt_s      = inc;
          limit_nxt_s    = limit;
          limit_en_nxt_s = limit_en;
          step_nxt_s     = {SW{1'b0}};
          result_nxt_s   = RES_NONE;
          hit_step_nxt_s = {SW{1'b0}};
          cycle_to_nxt_s = {SW{1'b0}};
          o_1_nxt_s      = 1'b0;
          hist_wr_en_s   = 1'b1;
          hist_wr_idx_s  = {SW{1'b0}};
          hist_wr_data_s = init_state;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (nxt_s == cur_r) begin
          state_nxt_s    = ST_DONE;
          done_nxt_s     = 1'b1;
          result_nxt_s   = RES_FIX;
          hit_step_nxt_s = k_s;
          o_1_nxt_s      = 1'b1;
        end else if (match_any_s) begin
          state_nxt_s    = ST_DONE;
          done_nxt_s     = 1'b1;
          result_nxt_s   = RES_CYCLE;
          hit_step_nxt_s = k_s;
          cycle_to_nxt_s = match_idx_s;
          o_1_nxt_s      = 1'b1;
        end else if (int'(k_s) == DEPTH) begin
          state_nxt_s    = ST_DONE;
          done_nxt_s     = 1'b1;
          result_nxt_s   = RES_NONE;
          hit_step_nxt_s = k_s;
          o_1_nxt_s      = 1'b0;
        end else begin
          cur_nxt_s      = nxt_s;
          step_nxt_s     = k_s;
          hist_wr_en_s   = 1'b1;
          hist_wr_idx_s  = k_s;
          hist_wr_data_s = nxt_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_RUN);
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cur_r      <= {WIDTH{1'b0}};
      inc_r      <= {WIDTH{1'b0}};
      limit_r    <= {WIDTH{1'b0}};
      limit_en_r <= 1'b0;
      step_r     <= {SW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= RES_NONE;
      hit_step_r <= {SW{1'b0}};
      cycle_to_r <= {SW{1'b0}};
      o_1_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cur_r      <= cur_nxt_s;
      inc_r      <= inc_nxt_s;
      limit_r    <= limit_nxt_s;
      limit_en_r <= limit_en_nxt_s;
      step_r     <= step_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      result_r   <= result_nxt_s;
      hit_step_r <= hit_step_nxt_s;
      cycle_to_r <= cycle_to_nxt_s;
      o_1_r      <= o_1_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign hit_step = hit_step_r;
  assign cycle_to = cycle_to_r;
  assign o_1      = o_1_r;

endmodule

// File: tb/tb_fixpoint_seq_checker.sv
// Scoreboard bench for fixpoint_seq_checker: expected verdicts are queued
// when a run is started and compared when done pulses.
module tb_fixpoint_seq_checker;

  localparam int WIDTH = 5;
  localparam int DEPTH = 5;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] init_state;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] limit;
  logic             limit_en;
  logic             busy;
  logic             done;
  logic [1:0]       result;
  logic [SW-1:0]    hit_step;
  logic [SW-1:0]    cycle_to;
  logic             o_1;

  typedef struct {
    logic [1:0] res;
    int         hit;
    int         cto;
    int         start_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  fixpoint_seq_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_state (init_state),
    .inc        (inc),
    .limit      (limit),
    .limit_en   (limit_en),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .hit_step   (hit_step),
    .cycle_to   (cycle_to),
    .o_1        (o_1)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure verdict latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive start, let edge E accept it, queue the expectation.
  task automatic start_run(input logic [4:0] i_init, input logic [4:0] i_inc,
                           input logic [4:0] i_lim, input logic i_en,
                           input logic [1:0] e_res, input int e_hit, input int e_cto);
    exp_t e;
    init_state = i_init;
    inc        = i_inc;
    limit      = i_lim;
    limit_en   = i_en;
    start      = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    e.res       = e_res;
    e.hit       = e_hit;
    e.cto       = e_cto;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    check_val("run_busy", 32'(busy), 32'd1);
    check_val("run_cleared_result", 32'(result), 32'd0);
    check_val("run_cleared_o1", 32'(o_1), 32'd0);
  endtask

  // Wait (bounded) for done and compare against the oldest queued expectation.
  task automatic wait_done(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    e = sb_q.pop_front();
    if (seen) begin
      check_val({tag, "_result"},   32'(result),   32'(e.res));
      check_val({tag, "_hit_step"}, 32'(hit_step), 32'(e.hit));
      check_val({tag, "_cycle_to"}, 32'(cycle_to), 32'(e.cto));
      check_val({tag, "_o1"},       32'(o_1),      32'(e.res != 2'd0));
      check_val({tag, "_busy"},     32'(busy),     32'd0);
      check_val({tag, "_latency"},  32'(cyc - e.start_cyc), 32'(e.hit));
    end else begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    init_state = 5'd0;
    inc        = 5'd0;
    limit      = 5'd0;
    limit_en   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",     32'(busy),     32'd0);
    check_val("rst_done",     32'(done),     32'd0);
    check_val("rst_result",   32'(result),   32'd0);
    check_val("rst_hit_step", 32'(hit_step), 32'd0);
    check_val("rst_cycle_to", 32'(cycle_to), 32'd0);
    check_val("rst_o1",       32'(o_1),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIX via saturation: 3,5,7,7
    start_run(5'd3, 5'd2, 5'd7, 1'b1, 2'd1, 3, 0);
    wait_done("fix");
    @(negedge clk);
    check_val("fix_done_pulse", 32'(done), 32'd0);
    check_val("fix_held", 32'(result), 32'd1);

    // Revisit of the initial state: 0,8,16,24,0
`ifdef HISTORY_CHECK_EN
    start_run(5'd0, 5'd8, 5'd0, 1'b0, 2'd2, 4, 0);
`else
    start_run(5'd0, 5'd8, 5'd0, 1'b0, 2'd0, 5, 0);
`endif
    wait_done("cycle");

    // Plain wrap counter never settles within DEPTH
    start_run(5'd0, 5'd1, 5'd0, 1'b0, 2'd0, 5, 0);
    wait_done("none");

    // inc==0 fixes at once, then restart from DONE with no idle cycle
    start_run(5'd9, 5'd0, 5'd0, 1'b0, 2'd1, 1, 0);
    wait_done("inc0");
    start_run(5'd31, 5'd3, 5'd4, 1'b1, 2'd1, 1, 0);
    wait_done("sat_init");

    // start during RUN is ignored; verdict follows the original inputs
    start_run(5'd0, 5'd1, 5'd0, 1'b0, 2'd0, 5, 0);
    init_state = 5'd7;
    inc        = 5'd0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");

    // Reset in the middle of a run
    start_run(5'd0, 5'd1, 5'd0, 1'b0, 2'd0, 5, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete(sb_q.size() - 1);
    check_val("midrst_busy",   32'(busy),   32'd0);
    check_val("midrst_done",   32'(done),   32'd0);
    check_val("midrst_result", 32'(result), 32'd0);
    check_val("midrst_o1",     32'(o_1),    32'd0);

    // Recovery after reset
    start_run(5'd3, 5'd2, 5'd7, 1'b1, 2'd1, 3, 0);
    wait_done("recover");

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
